multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter ALU_OP_WIDTH, default 3, is the width of ALU_Op_o and must be at least 3.
REQ-002 Parameter MEM_TIMEOUT, default 16, is the maximum number of cycles to wait for Mem_Ready_i before aborting, range 1 to 255.
REQ-003 clk  input  1  is the single clock; all state changes on its rising edge.
REQ-004 reset  input  1  is a synchronous, active-low reset.
REQ-005 OP_i  input  7  is the opcode field of the instruction bus, sampled only in FETCH.
REQ-006 Mem_Ready_i  input  1  is the memory handshake: the access completes in a cycle where it is high.
REQ-007 PC_Write_o, IR_Write_o, Mem_Read_o, Mem_Write_o, Reg_Write_o, Mem_to_Reg_o, ALU_Src_o, Branch_o  output  1 each  are the datapath strobes.
REQ-008 ALU_Op_o  output  ALU_OP_WIDTH  is the ALU class code.
REQ-009 Instr_Done_o  output  1  is a one-cycle pulse in the last cycle of each instruction.
REQ-010 Mem_Timeout_o  output  1  is a one-cycle pulse when a memory wait is aborted.
REQ-011 State_o  output  3  is the current state encoding.

Function
REQ-012 The state encodings SHALL be: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4, TRAP=5.
REQ-013 FETCH: Mem_Read_o=1; when Mem_Ready_i=1, assert IR_Write_o and PC_Write_o for that cycle, latch OP_i into an opcode register, and go to DECODE.
REQ-014 DECODE SHALL last one cycle and then go to EXECUTE.
- Exception: an unrecognised latched opcode goes to FETCH (TRAP when the macro is defined, see REQ-027).
REQ-015 Recognised opcodes and their ALU_Op_o values (zero-extended to ALU_OP_WIDTH):
- 0x33: 0.
- 0x13, 0x03, 0x23, 0x67: 1.
- 0x37: 2.
- 0x63: 4.
- 0x6F: 0.
REQ-016 EXECUTE SHALL drive ALU_Op_o per the latched class.
- ALU_Src_o=1 for 0x13, 0x03, 0x23, 0x67 and 0x37.
- Branch_o=1 for 0x63, 0x6F and 0x67.
REQ-017 EXECUTE next state SHALL be:
- MEM for 0x03 and 0x23.
- FETCH for 0x63, with Instr_Done_o=1.
- WB for all other classes.
REQ-018 MEM SHALL hold ALU_Src_o=1, with Mem_Read_o=1 for 0x03 and Mem_Write_o=1 for 0x23.
- On Mem_Ready_i=1: load goes to WB; store goes to FETCH with Instr_Done_o=1.
REQ-019 WB SHALL assert Reg_Write_o=1 and Instr_Done_o=1, assert Mem_to_Reg_o=1 only for 0x03, and go to FETCH.
REQ-020 Instruction latencies with zero-wait memory SHALL be:
- Branch: 3 cycles.
- R, I-logic, U, JAL, JALR and store: 4 cycles.
- Load: 5 cycles.
- Each wait cycle in FETCH or MEM adds one cycle.
REQ-021 Outputs SHALL be decoded from the state and the latched opcode only (Moore).
- Exception: Mem_Ready_i-qualified strobes (IR_Write_o, PC_Write_o, MEM-state Instr_Done_o).
- Any strobe not listed for a state is 0.
REQ-022 An 8-bit wait counter SHALL clear on entry to FETCH or MEM and increment each cycle Mem_Ready_i=0 in those states.
- When it reaches MEM_TIMEOUT-1 with Mem_Ready_i still 0: pulse Mem_Timeout_o, then go to FETCH without PC_Write_o or Instr_Done_o.
REQ-023 Mem_Ready_i=1 in the same cycle as the timeout threshold SHALL take priority: the access completes and there is no timeout.
REQ-024 Mem_Ready_i SHALL be ignored in DECODE, EXECUTE and WB.

Reset
REQ-025 While reset=0 at a clock edge, the block SHALL enter FETCH and clear the opcode register and wait counter, regardless of the current state (including mid-MEM).
REQ-026 During reset, all strobe outputs, Instr_Done_o and Mem_Timeout_o SHALL be 0, ALU_Op_o=0 and State_o=0.
- Exception: Mem_Read_o=1, as FETCH dictates, from the first cycle after reset release.

Configuration
REQ-027 With macro ILLEGAL_TRAP_EN defined:
- An unrecognised opcode in DECODE goes to TRAP.
- TRAP holds all strobes at 0, holds State_o=5, and stays until reset.
- A 1-bit Illegal_Instr_o output is 1 only in TRAP.
REQ-028 Without ILLEGAL_TRAP_EN: there is no TRAP state and no Illegal_Instr_o port; an unrecognised opcode returns to FETCH after DECODE with no Instr_Done_o.

Verification
REQ-029 Reset low 2 cycles, then OP_i=0x33 with Mem_Ready_i=1 -> States 0,1,2,4; Reg_Write_o=1 and Instr_Done_o=1 in cycle 4; ALU_Op_o=0 in EXECUTE.
REQ-030 OP_i=0x03, Mem_Ready_i low for 2 cycles in MEM -> 7 cycles total; Mem_to_Reg_o=1 in WB; Mem_Read_o=1 throughout MEM.
REQ-031 OP_i=0x63 -> 3 cycles; Branch_o=1 and ALU_Op_o=4 in EXECUTE; Reg_Write_o never 1.
REQ-032 MEM_TIMEOUT=4, Mem_Ready_i held 0 in FETCH -> Mem_Timeout_o pulses in the 4th FETCH cycle, FETCH restarts, PC_Write_o stays 0; a repeat run with Mem_Ready_i=1 in that 4th cycle completes the fetch instead.
REQ-033 OP_i=0x7F -> with ILLEGAL_TRAP_EN: State_o=5 and Illegal_Instr_o=1 until reset; without it: back to FETCH after DECODE.
REQ-034 reset=0 asserted in the MEM cycle of a 0x23 store -> Mem_Write_o=0 on the next cycle and State_o=0.

Source files
------------

// File: rtl/multicycle_control.sv
// Multicycle instruction sequencer: FETCH/DECODE/EXECUTE/MEM/WB with memory-wait timeout.
// Define ILLEGAL_TRAP_EN to trap unrecognised opcodes in a sticky TRAP state.
module multicycle_control #(
   parameter int unsigned ALU_OP_WIDTH = 3,
   parameter int unsigned MEM_TIMEOUT  = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [6:0]              OP_i,
   input  logic                    Mem_Ready_i,
   output logic                    PC_Write_o,
   output logic                    IR_Write_o,
   output logic                    Mem_Read_o,
   output logic                    Mem_Write_o,
   output logic                    Reg_Write_o,
   output logic                    Mem_to_Reg_o,
   output logic                    ALU_Src_o,
   output logic                    Branch_o,
   output logic [ALU_OP_WIDTH-1:0] ALU_Op_o,
   output logic                    Instr_Done_o,
   output logic                    Mem_Timeout_o,
   output logic [2:0]              State_o
`ifdef ILLEGAL_TRAP_EN
   ,
   output logic                    Illegal_Instr_o
`endif
);

   localparam logic [2:0] StFetch   = 3'd0;
   localparam logic [2:0] StDecode  = 3'd1;
   localparam logic [2:0] StExecute = 3'd2;
   localparam logic [2:0] StMem     = 3'd3;
   localparam logic [2:0] StWb      = 3'd4;
   localparam logic [2:0] StTrap    = 3'd5;

   localparam logic [6:0] OpR      = 7'h33;
   localparam logic [6:0] OpImm    = 7'h13;
   localparam logic [6:0] OpLoad   = 7'h03;
   localparam logic [6:0] OpStore  = 7'h23;
   localparam logic [6:0] OpJalr   = 7'h67;
   localparam logic [6:0] OpLui    = 7'h37;
   localparam logic [6:0] OpBranch = 7'h63;
   localparam logic [6:0] OpJal    = 7'h6F;

   logic [2:0]              r_state;
   logic [6:0]              r_opcode;
   logic [7:0]              r_wait_cnt;
   logic [2:0]              w_state_d;
   logic [6:0]              w_opcode_d;
   logic [7:0]              w_wait_d;
   logic                    w_legal;
   logic                    w_timeout;
   logic [ALU_OP_WIDTH-1:0] w_alu_op;
   logic                    w_is_load;
   logic                    w_is_store;

   assign w_is_load  = (r_opcode == OpLoad);
   assign w_is_store = (r_opcode == OpStore);

   always_comb begin
      w_legal  = 1'b1;
      w_alu_op = '0;
      case (r_opcode)
         OpR, OpJal:                     w_alu_op = ALU_OP_WIDTH'(3'd0);
         OpImm, OpLoad, OpStore, OpJalr: w_alu_op = ALU_OP_WIDTH'(3'd1);
         OpLui:                          w_alu_op = ALU_OP_WIDTH'(3'd2);
         OpBranch:                       w_alu_op = ALU_OP_WIDTH'(3'd4);
         default:                        w_legal  = 1'b0;
      endcase
   end

   // Ready on the threshold cycle wins over the timeout.
   assign w_timeout = ((r_state == StFetch) || (r_state == StMem)) && !Mem_Ready_i &&
                      (r_wait_cnt == 8'(MEM_TIMEOUT - 1));

   always_comb begin
      PC_Write_o    = 1'b0;
      IR_Write_o    = 1'b0;
      Mem_Read_o    = 1'b0;
      Mem_Write_o   = 1'b0;
      Reg_Write_o   = 1'b0;
      Mem_to_Reg_o  = 1'b0;
      ALU_Src_o     = 1'b0;
      Branch_o      = 1'b0;
      ALU_Op_o      = '0;
      Instr_Done_o  = 1'b0;
      Mem_Timeout_o = 1'b0;
      State_o       = r_state;
`ifdef ILLEGAL_TRAP_EN
      Illegal_Instr_o = 1'b0;
`endif
      w_state_d  = r_state;
      w_opcode_d = r_opcode;
      w_wait_d   = '0;
      case (r_state)
         StFetch: begin
            Mem_Read_o = 1'b1;
            if (Mem_Ready_i) begin
               IR_Write_o = 1'b1;
               PC_Write_o = 1'b1;
               w_opcode_d = OP_i;
               w_state_d  = StDecode;
            end else if (w_timeout) begin
               Mem_Timeout_o = 1'b1;
            end else begin
               w_wait_d = r_wait_cnt + 8'd1;
            end
         end
         StDecode: begin
`ifdef ILLEGAL_TRAP_EN
            w_state_d = w_legal ? StExecute : StTrap;
`else
            w_state_d = w_legal ? StExecute : StFetch;
`endif
         end
         StExecute: begin
            ALU_Op_o  = w_alu_op;
            ALU_Src_o = (r_opcode == OpImm) || w_is_load || w_is_store ||
                        (r_opcode == OpJalr) || (r_opcode == OpLui);
            Branch_o  = (r_opcode == OpBranch) || (r_opcode == OpJal) || (r_opcode == OpJalr);
            if (w_is_load || w_is_store) begin
               w_state_d = StMem;
            end else if (r_opcode == OpBranch) begin
               Instr_Done_o = 1'b1;
               w_state_d    = StFetch;
            end else begin
               w_state_d = StWb;
            end
         end
         StMem: begin
            ALU_Src_o   = 1'b1;
            Mem_Read_o  = w_is_load;
            Mem_Write_o = w_is_store;
            if (Mem_Ready_i) begin
               Instr_Done_o = w_is_store;
               w_state_d    = w_is_load ? StWb : StFetch;
            end else if (w_timeout) begin
               Mem_Timeout_o = 1'b1;
               w_state_d     = StFetch;
            end else begin
               w_wait_d = r_wait_cnt + 8'd1;
            end
         end
         StWb: begin
            Reg_Write_o  = 1'b1;
            Instr_Done_o = 1'b1;
            Mem_to_Reg_o = w_is_load;
            w_state_d    = StFetch;
         end
`ifdef ILLEGAL_TRAP_EN
         StTrap: begin
            Illegal_Instr_o = 1'b1;
         end
`endif
         default: w_state_d = StFetch;
      endcase
      // Outputs are forced quiet for as long as reset is held low.
      if (!reset) begin
         PC_Write_o    = 1'b0;
         IR_Write_o    = 1'b0;
         Mem_Read_o    = 1'b0;
         Mem_Write_o   = 1'b0;
         Reg_Write_o   = 1'b0;
         Mem_to_Reg_o  = 1'b0;
         ALU_Src_o     = 1'b0;
         Branch_o      = 1'b0;
         ALU_Op_o      = '0;
         Instr_Done_o  = 1'b0;
         Mem_Timeout_o = 1'b0;
         State_o       = StFetch;
`ifdef ILLEGAL_TRAP_EN
         Illegal_Instr_o = 1'b0;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state    <= StFetch;
         r_opcode   <= '0;
         r_wait_cnt <= '0;
      end else begin
         r_state    <= w_state_d;
         r_opcode   <= w_opcode_d;
         r_wait_cnt <= w_wait_d;
      end
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed scenarios plus random
// opcode/ready/reset stimulus compared each cycle against a behavioural model.
module tb_multicycle_control;

   localparam int unsigned Timeout = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [6:0] OP_i = '0;
   logic       Mem_Ready_i = 1'b0;
   logic       PC_Write_o, IR_Write_o, Mem_Read_o, Mem_Write_o, Reg_Write_o;
   logic       Mem_to_Reg_o, ALU_Src_o, Branch_o, Instr_Done_o, Mem_Timeout_o;
   logic [2:0] ALU_Op_o;
   logic [2:0] State_o;
`ifdef ILLEGAL_TRAP_EN
   logic       Illegal_Instr_o;
`endif

   always #5 clk = ~clk;

   multicycle_control #(
      .ALU_OP_WIDTH (3),
      .MEM_TIMEOUT  (Timeout)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .OP_i          (OP_i),
      .Mem_Ready_i   (Mem_Ready_i),
      .PC_Write_o    (PC_Write_o),
      .IR_Write_o    (IR_Write_o),
      .Mem_Read_o    (Mem_Read_o),
      .Mem_Write_o   (Mem_Write_o),
      .Reg_Write_o   (Reg_Write_o),
      .Mem_to_Reg_o  (Mem_to_Reg_o),
      .ALU_Src_o     (ALU_Src_o),
      .Branch_o      (Branch_o),
      .ALU_Op_o      (ALU_Op_o),
      .Instr_Done_o  (Instr_Done_o),
      .Mem_Timeout_o (Mem_Timeout_o),
      .State_o       (State_o)
`ifdef ILLEGAL_TRAP_EN
      ,
      .Illegal_Instr_o (Illegal_Instr_o)
`endif
   );

   int n_checks = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // Behavioural model: phase number (0..5 as the state encodings), latched opcode, wait count.
   int m_state = 0;
   int m_op = 0;
   int m_wait = 0;
   int e_pcw, e_irw, e_mrd, e_mwr, e_rw, e_m2r, e_src, e_br, e_alu, e_done, e_to, e_state, e_ill;

   function automatic bit legal(input int op);
      return op inside {'h33, 'h13, 'h03, 'h23, 'h67, 'h37, 'h63, 'h6F};
   endfunction

   function automatic int alu_class(input int op);
      if (op inside {'h13, 'h03, 'h23, 'h67}) return 1;
      if (op == 'h37) return 2;
      if (op == 'h63) return 4;
      return 0;
   endfunction

   function automatic void model_eval();
      e_pcw = 0; e_irw = 0; e_mrd = 0; e_mwr = 0; e_rw = 0; e_m2r = 0; e_src = 0;
      e_br = 0; e_alu = 0; e_done = 0; e_to = 0; e_state = 0; e_ill = 0;
      if (!reset) return;
      e_state = m_state;
      case (m_state)
         0: begin
            e_mrd = 1;
            e_irw = int'(Mem_Ready_i);
            e_pcw = int'(Mem_Ready_i);
            e_to  = int'(!Mem_Ready_i && m_wait == Timeout - 1);
         end
         2: begin
            e_alu  = alu_class(m_op);
            e_src  = int'(m_op inside {'h13, 'h03, 'h23, 'h67, 'h37});
            e_br   = int'(m_op inside {'h63, 'h6F, 'h67});
            e_done = int'(m_op == 'h63);
         end
         3: begin
            e_src  = 1;
            e_mrd  = int'(m_op == 'h03);
            e_mwr  = int'(m_op == 'h23);
            e_done = int'(Mem_Ready_i && m_op == 'h23);
            e_to   = int'(!Mem_Ready_i && m_wait == Timeout - 1);
         end
         4: begin
            e_rw  = 1;
            e_done = 1;
            e_m2r = int'(m_op == 'h03);
         end
         5: e_ill = 1;
         default: ;
      endcase
   endfunction

   function automatic void model_advance();
      if (!reset) begin
         m_state = 0; m_op = 0; m_wait = 0;
         return;
      end
      model_eval();
      case (m_state)
         0: begin
            if (Mem_Ready_i) begin
               m_op = int'(OP_i); m_state = 1; m_wait = 0;
            end else if (e_to != 0) m_wait = 0;
            else m_wait++;
         end
`ifdef ILLEGAL_TRAP_EN
         1: m_state = legal(m_op) ? 2 : 5;
`else
         1: m_state = legal(m_op) ? 2 : 0;
`endif
         2: m_state = (m_op == 'h03 || m_op == 'h23) ? 3 : ((m_op == 'h63) ? 0 : 4);
         3: begin
            if (Mem_Ready_i) begin
               m_state = (m_op == 'h03) ? 4 : 0; m_wait = 0;
            end else if (e_to != 0) begin
               m_state = 0; m_wait = 0;
            end else m_wait++;
         end
         4: m_state = 0;
         default: ;
      endcase
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         model_eval();
         check("state", int'(State_o), e_state);
         check("pc_write", int'(PC_Write_o), e_pcw);
         check("ir_write", int'(IR_Write_o), e_irw);
         check("mem_read", int'(Mem_Read_o), e_mrd);
         check("mem_write", int'(Mem_Write_o), e_mwr);
         check("reg_write", int'(Reg_Write_o), e_rw);
         check("mem_to_reg", int'(Mem_to_Reg_o), e_m2r);
         check("alu_src", int'(ALU_Src_o), e_src);
         check("branch", int'(Branch_o), e_br);
         check("alu_op", int'(ALU_Op_o), e_alu);
         check("instr_done", int'(Instr_Done_o), e_done);
         check("mem_timeout", int'(Mem_Timeout_o), e_to);
`ifdef ILLEGAL_TRAP_EN
         check("illegal", int'(Illegal_Instr_o), e_ill);
`endif
      end
   end

   task automatic step(input bit rst, input int op, input bit rdy);
      @(posedge clk);
      model_advance();
      #1;
      reset = rst;
      OP_i = 7'(op);
      Mem_Ready_i = rdy;
      @(negedge clk);
   endtask

   int ops[10] = '{'h33, 'h13, 'h03, 'h23, 'h67, 'h37, 'h63, 'h6F, 'h7F, 'h00};

   initial begin
      chk_en = 1'b1;
      // Reset held for two cycles
      step(0, 0, 0);
      check("rst_state", int'(State_o), 0);
      check("rst_mrd", int'(Mem_Read_o), 0);
      step(0, 0, 0);
      // R-type, zero-wait: states 0,1,2,4
      step(1, 'h33, 1);
      check("r_c1_state", int'(State_o), 0);
      check("r_c1_mrd", int'(Mem_Read_o), 1);
      check("r_c1_pcw", int'(PC_Write_o), 1);
      step(1, 0, 0);
      check("r_c2_state", int'(State_o), 1);
      step(1, 0, 1);
      check("r_c3_state", int'(State_o), 2);
      check("r_c3_alu", int'(ALU_Op_o), 0);
      step(1, 0, 0);
      check("r_c4_state", int'(State_o), 4);
      check("r_c4_rw", int'(Reg_Write_o), 1);
      check("r_c4_done", int'(Instr_Done_o), 1);
      // Load with two MEM wait cycles: done in cycle 7
      step(1, 'h03, 1);
      check("ld_c1_irw", int'(IR_Write_o), 1);
      step(1, 0, 0);
      step(1, 0, 0);
      check("ld_c3_alu", int'(ALU_Op_o), 1);
      check("ld_c3_src", int'(ALU_Src_o), 1);
      step(1, 0, 0);
      check("ld_c4_state", int'(State_o), 3);
      check("ld_c4_mrd", int'(Mem_Read_o), 1);
      step(1, 0, 0);
      check("ld_c5_mrd", int'(Mem_Read_o), 1);
      step(1, 0, 1);
      check("ld_c6_mrd", int'(Mem_Read_o), 1);
      check("ld_c6_done", int'(Instr_Done_o), 0);
      step(1, 0, 0);
      check("ld_c7_state", int'(State_o), 4);
      check("ld_c7_m2r", int'(Mem_to_Reg_o), 1);
      check("ld_c7_done", int'(Instr_Done_o), 1);
      // Branch: three cycles
      step(1, 'h63, 1);
      step(1, 0, 0);
      step(1, 0, 0);
      check("br_c3_branch", int'(Branch_o), 1);
      check("br_c3_alu", int'(ALU_Op_o), 4);
      check("br_c3_done", int'(Instr_Done_o), 1);
      // Fetch timeout after four idle cycles (first idle fetch cycle is this one)
      step(1, 0, 0);
      check("to_c1_state", int'(State_o), 0);
      step(1, 0, 0);
      step(1, 0, 0);
      check("to_c3_to", int'(Mem_Timeout_o), 0);
      step(1, 0, 0);
      check("to_c4_to", int'(Mem_Timeout_o), 1);
      check("to_c4_pcw", int'(PC_Write_o), 0);
      step(1, 0, 0);
      check("to_c5_to", int'(Mem_Timeout_o), 0);
      check("to_c5_state", int'(State_o), 0);
      step(1, 0, 0);
      step(1, 0, 0);
      // Ready on the threshold cycle completes the fetch (illegal opcode fetched)
      step(1, 'h7F, 1);
      check("tor_c4_to", int'(Mem_Timeout_o), 0);
      check("tor_c4_pcw", int'(PC_Write_o), 1);
      step(1, 0, 0);
      check("ill_dec_state", int'(State_o), 1);
      step(1, 0, 0);
`ifdef ILLEGAL_TRAP_EN
      check("ill_state", int'(State_o), 5);
      check("ill_flag", int'(Illegal_Instr_o), 1);
      step(1, 0, 1);
      check("ill_hold", int'(State_o), 5);
`else
      check("ill_state", int'(State_o), 0);
      check("ill_done", int'(Instr_Done_o), 0);
`endif
      step(0, 0, 0);
      // Reset in the MEM cycle of a store
      step(1, 'h23, 1);
      step(1, 0, 0);
      step(1, 0, 0);
      step(1, 0, 0);
      check("st_mem_state", int'(State_o), 3);
      check("st_mem_mwr", int'(Mem_Write_o), 1);
      step(0, 0, 0);
      check("st_rst_mwr", int'(Mem_Write_o), 0);
      step(1, 0, 0);
      check("st_after_state", int'(State_o), 0);
      check("st_after_mwr", int'(Mem_Write_o), 0);
      check("st_after_mrd", int'(Mem_Read_o), 1);
      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(99) != 0, ops[$urandom_range(9)], $urandom_range(9) < 6);
      end
      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
